// File: rtl/muladd_sched.sv
// Round-robin scheduler sharing one HLS muladd core (ap_ctrl_hs) between NREQ
// requesters: grants the core, routes its BRAM reads, and returns result + cycle count.
module muladd_sched #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RES_W  = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [RES_W-1:0]         rsp_data,
    output logic [15:0]              rsp_cycles,
    output logic [ADDR_W-1:0]        mem_a_address,
    output logic [NREQ-1:0]          mem_a_ce,
    input  logic [NREQ*DATA_W-1:0]   mem_a_q,
    output logic [ADDR_W-1:0]        mem_b_address,
    output logic [NREQ-1:0]          mem_b_ce,
    input  logic [NREQ*DATA_W-1:0]   mem_b_q,
    output logic                     core_ap_start,
    input  logic                     core_ap_done,
    input  logic                     core_ap_idle,
    input  logic                     core_ap_ready,
    input  logic [ADDR_W-1:0]        core_a_address0,
    input  logic [ADDR_W-1:0]        core_b_address0,
    input  logic                     core_a_ce0,
    input  logic                     core_b_ce0,
    output logic [DATA_W-1:0]        core_a_q0,
    output logic [DATA_W-1:0]        core_b_q0,
    input  logic [RES_W-1:0]         core_ap_return,
    output logic [1:0]               state_dbg
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win_q;
    logic [15:0]       cnt;
    logic [15:0]       cnt_inc;

    logic [2*NREQ-1:0] req_dbl;
    logic              win_found;
    logic [PW-1:0]     win_off;
    logic [PW:0]       win_sum;
    logic [PW-1:0]     win_idx;

    assign state_dbg = state;
    assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // Rotate req so bit 0 is the requester at ptr; the first set bit is the winner.
    always_comb begin
        req_dbl   = {req, req} >> ptr;
        win_found = 1'b0;
        win_off   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!win_found && req_dbl[j]) begin
                win_found = 1'b1;
                win_off   = PW'(j);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, win_off};
        if (win_sum >= NREQ_W)
            win_sum = win_sum - NREQ_W;
        win_idx = win_sum[PW-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            win_q         <= '0;
            cnt           <= '0;
            gnt           <= '0;
            busy          <= 1'b0;
            core_ap_start <= 1'b0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_cycles    <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (core_ap_idle && win_found) begin
                        gnt           <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        win_q         <= win_idx;
                        core_ap_start <= 1'b1;
                        busy          <= 1'b1;
                        cnt           <= '0;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    cnt <= cnt_inc;
                    if (core_ap_ready) begin
                        core_ap_start <= 1'b0;
                        if (core_ap_done) begin
                            rsp_data   <= core_ap_return;
                            rsp_cycles <= cnt_inc;
                            rsp_valid  <= gnt;
                            state      <= S_RESP;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt <= cnt_inc;
                    if (core_ap_done) begin
                        rsp_data   <= core_ap_return;
                        rsp_cycles <= cnt_inc;
                        rsp_valid  <= gnt;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read routing is keyed only by the registered grant, so it is stable for the whole job.
    assign mem_a_address = core_a_address0;
    assign mem_b_address = core_b_address0;
    assign mem_a_ce      = {NREQ{core_a_ce0}} & gnt;
    assign mem_b_ce      = {NREQ{core_b_ce0}} & gnt;

    always_comb begin
        core_a_q0 = '0;
        core_b_q0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                core_a_q0 = core_a_q0 | mem_a_q[i*DATA_W +: DATA_W];
                core_b_q0 = core_b_q0 | mem_b_q[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
